axis_arbiter: RTL and testbench

- Round-robin arbiter that merges COUNT valid/ready input streams onto one output stream.
- With PACKET=1 it is packet-aware: a grant is held from the first beat of a packet until its last beat.
- The output stage is a single registered slot (odata/olast/ovalid), so it can sit directly in front of a register stage or FIFO.
- Typical use: sharing one downstream stream sink (serializer, FIFO, USB/UART path) among several producers.

---
 rtl/axis_arbiter.sv | 118 +++++++++++
 tb/tb_axis_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_arbiter.sv
// Round-robin arbiter merging COUNT valid/ready streams into one registered output slot.
// With PACKET=1 a grant is held from the first beat of a packet through its ilast beat.
module axis_arbiter #(
  parameter int WIDTH  = 8,
  parameter int COUNT  = 4,
  parameter int PACKET = 1
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic [COUNT*WIDTH-1:0] idata,
  input  logic [COUNT-1:0]       ivalid,
  input  logic [COUNT-1:0]       ilast,
  output logic [COUNT-1:0]       iready,
  output logic [WIDTH-1:0]       odata,
  output logic                   olast,
  output logic                   ovalid,
  input  logic                   oready,
  output logic [COUNT-1:0]       grant
);

  localparam int PTR_W = (COUNT > 1) ? $clog2(COUNT) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state, state_next;
  logic [PTR_W-1:0]   ptr, ptr_next;
  logic [PTR_W-1:0]   winner, gidx;
  logic [PTR_W:0]     scan;
  logic               found;
  logic [COUNT-1:0]   grant_next;
  logic               slot_free, xfer, end_pkt;
  logic [WIDTH-1:0]   in_data;
  logic               in_last;

  // Scan downward so the requester closest to ptr is the last (winning) assignment.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    scan   = '0;
    for (int k = COUNT - 1; k >= 0; k--) begin
      scan = {1'b0, ptr} + (PTR_W + 1)'(k);
      if (scan >= (PTR_W + 1)'(COUNT)) scan = scan - (PTR_W + 1)'(COUNT);
      if (ivalid[scan[PTR_W-1:0]]) begin
        winner = scan[PTR_W-1:0];
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    gidx    = '0;
    in_data = '0;
    in_last = 1'b0;
    for (int i = 0; i < COUNT; i++) begin
      if (grant[i]) begin
        gidx    = PTR_W'(i);
        in_data = idata[i*WIDTH +: WIDTH];
        in_last = ilast[i];
      end
    end
  end

  // iready is a function of grant and the output slot only, never of the inputs.
  assign slot_free = !ovalid || oready;
  assign iready    = grant & {COUNT{slot_free}};
  assign xfer      = |(iready & ivalid);
  assign end_pkt   = (PACKET == 0) || in_last;

  always_comb begin
    state_next = state;
    grant_next = grant;
    ptr_next   = ptr;
    case (state)
      IDLE: begin
        if (found) begin
          state_next = BUSY;
          grant_next = COUNT'(1) << winner;
        end
      end
      BUSY: begin
        if (xfer && end_pkt) begin
          state_next = IDLE;
          grant_next = '0;
          ptr_next   = (gidx == PTR_W'(COUNT - 1)) ? '0 : gidx + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state <= IDLE;
      grant <= '0;
      ptr   <= '0;
    end else begin
      state <= state_next;
      grant <= grant_next;
      ptr   <= ptr_next;
    end
  end

  // Output slot: load on an input transfer, otherwise drain when downstream accepts.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      ovalid <= 1'b0;
      olast  <= 1'b0;
      odata  <= '0;
    end else if (xfer) begin
      ovalid <= 1'b1;
      olast  <= (PACKET != 0) && in_last;
      odata  <= in_data;
    end else if (oready) begin
      ovalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axis_arbiter.sv
// Directed bench for axis_arbiter: stream sources fed from queues, scoreboard monitor on the output.
module tb_axis_arbiter;

  localparam int W = 8;
  localparam int N = 4;

  logic           clock;
  logic           resetn;
  logic [N*W-1:0] idata;
  logic [N-1:0]   ivalid, ilast;
  logic           oready;

  logic [N-1:0]   iready_a, grant_a, iready_b, grant_b;
  logic [W-1:0]   odata_a, odata_b;
  logic           olast_a, ovalid_a, olast_b, ovalid_b;

  axis_arbiter #(.WIDTH(W), .COUNT(N), .PACKET(1)) u_pkt (
    .clock(clock), .resetn(resetn), .idata(idata), .ivalid(ivalid), .ilast(ilast),
    .iready(iready_a), .odata(odata_a), .olast(olast_a), .ovalid(ovalid_a),
    .oready(oready), .grant(grant_a));

  axis_arbiter #(.WIDTH(W), .COUNT(N), .PACKET(0)) u_beat (
    .clock(clock), .resetn(resetn), .idata(idata), .ivalid(ivalid), .ilast(ilast),
    .iready(iready_b), .odata(odata_b), .olast(olast_b), .ovalid(ovalid_b),
    .oready(oready), .grant(grant_b));

  typedef struct {logic [W-1:0] d; logic l; int gap;} beat_t;
  typedef struct {logic [W-1:0] d; logic l;} exp_t;

  beat_t srcq[N][$];
  exp_t  expq[$];
  int    popcyc[$];
  int    compared = 0;
  int    mismatched = 0;
  int    cyc = 0;
  logic  sel = 1'b0;
  logic  mon_en = 1'b0;
  logic [N-1:0] acc;

  logic [N-1:0] m_iready, m_grant;
  logic [W-1:0] m_odata;
  logic         m_olast, m_ovalid;
  assign m_iready = sel ? iready_b : iready_a;
  assign m_grant  = sel ? grant_b  : grant_a;
  assign m_odata  = sel ? odata_b  : odata_a;
  assign m_olast  = sel ? olast_b  : olast_a;
  assign m_ovalid = sel ? ovalid_b : ovalid_a;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic send(input int s, input logic [W-1:0] d, input logic l, input int gap);
    beat_t b;
    b.d = d; b.l = l; b.gap = gap;
    srcq[s].push_back(b);
  endtask

  task automatic expect_beat(input logic [W-1:0] d, input logic l);
    exp_t e;
    e.d = d; e.l = l;
    expq.push_back(e);
  endtask

  task automatic do_reset(input logic s);
    @(negedge clock);
    mon_en = 1'b0;
    for (int i = 0; i < N; i++) srcq[i].delete();
    expq.delete();
    resetn = 1'b0;
    sel = s;
    tick(2);
    resetn = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic wait_drain(input int maxc);
    int n;
    logic done;
    n = 0;
    done = 1'b0;
    while (!done && n < maxc) begin
      @(negedge clock);
      n++;
      done = (expq.size() == 0) && !m_ovalid && (m_grant == '0);
      for (int i = 0; i < N; i++) if (srcq[i].size() != 0) done = 1'b0;
    end
    check("drain", done, 1);
  endtask

  // Source driver: handshake sampled mid-cycle, next beat presented just after the edge.
  initial begin
    beat_t b;
    ivalid = '0;
    ilast  = '0;
    idata  = '0;
    forever begin
      @(negedge clock);
      acc = ivalid & (sel ? iready_b : iready_a);
      @(posedge clock);
      #1;
      for (int s = 0; s < N; s++) begin
        if (acc[s] && srcq[s].size() > 0) srcq[s].delete(0);
        ivalid[s] = 1'b0;
        ilast[s]  = 1'b0;
        if (srcq[s].size() > 0) begin
          b = srcq[s][0];
          if (b.gap > 0) begin
            b.gap--;
            srcq[s][0] = b;
          end else begin
            ivalid[s]       = 1'b1;
            ilast[s]        = b.l;
            idata[s*W +: W] = b.d;
          end
        end
      end
    end
  end

  // Scoreboard monitor: one pop per output transfer.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (mon_en && m_ovalid === 1'b1 && oready === 1'b1) begin
        if (expq.size() == 0) begin
          check("unexpected_beat", {24'h0, m_odata}, 32'hFFFF);
        end else begin
          e = expq.pop_front();
          check("odata", m_odata, e.d);
          check("olast", m_olast, e.l);
          popcyc.push_back(cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0;
    oready = 1'b1;
    tick(2);
    check("rst_grant", m_grant, 0);
    check("rst_ovalid", m_ovalid, 0);
    check("rst_olast", m_olast, 0);
    check("rst_odata", m_odata, 0);
    check("rst_iready", m_iready, 0);
    resetn = 1'b1;
    mon_en = 1'b1;

    // Single stream 2 packet A,B,C.
    send(2, 8'hA1, 0, 0); send(2, 8'hB2, 0, 0); send(2, 8'hC3, 1, 0);
    expect_beat(8'hA1, 0); expect_beat(8'hB2, 0); expect_beat(8'hC3, 1);
    tick(1);
    check("t1_grant_idle", m_grant, 4'b0000);
    tick(1);
    check("t1_grant", m_grant, 4'b0100);
    check("t1_iready", m_iready, 4'b0100);
    tick(1);
    check("t1_beatA", m_odata, 8'hA1);
    tick(1);
    check("t1_beatB", m_odata, 8'hB2);
    tick(1);
    check("t1_beatC", m_odata, 8'hC3);
    check("t1_lastC", m_olast, 1);
    check("t1_grant_end", m_grant, 0);
    wait_drain(50);

    // All four streams with single-beat packets: order 0,1,2,3,0, one beat per 2 cycles.
    do_reset(0);
    popcyc.delete();
    for (int s = 0; s < N; s++) send(s, 8'h10 + 8'(s), 1, 0);
    send(0, 8'h20, 1, 0);
    for (int s = 0; s < N; s++) expect_beat(8'h10 + 8'(s), 1);
    expect_beat(8'h20, 1);
    tick(2);
    check("t2_first_grant", m_grant, 4'b0001);
    wait_drain(100);
    check("t2_beats", popcyc.size(), 5);
    for (int i = 1; i < popcyc.size(); i++)
      check("t2_spacing", popcyc[i] - popcyc[i-1], 2);

    // Stream 1 stalls mid-packet for 5 cycles while stream 3 waits.
    send(1, 8'h31, 0, 0); send(1, 8'h32, 0, 5); send(1, 8'h33, 1, 0);
    send(3, 8'h3F, 1, 0);
    expect_beat(8'h31, 0); expect_beat(8'h32, 0); expect_beat(8'h33, 1);
    expect_beat(8'h3F, 1);
    tick(3);
    for (int i = 0; i < 5; i++) begin
      check("t3_grant_held", m_grant, 4'b0010);
      check("t3_iready3", m_iready[3], 0);
      tick(1);
    end
    wait_drain(100);

    // Backpressure: downstream stalls for 4 cycles during a stream 0 packet.
    send(0, 8'h41, 0, 0); send(0, 8'h42, 0, 0); send(0, 8'h43, 0, 0); send(0, 8'h44, 1, 0);
    expect_beat(8'h41, 0); expect_beat(8'h42, 0); expect_beat(8'h43, 0); expect_beat(8'h44, 1);
    tick(3);
    @(posedge clock); #2;
    oready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("t4_iready", m_iready, 0);
      check("t4_ovalid", m_ovalid, 1);
      check("t4_odata_hold", m_odata, 8'h42);
    end
    @(posedge clock); #2;
    oready = 1'b1;
    wait_drain(100);

    // Beat-wise arbitration: grants alternate and ilast is ignored.
    do_reset(1);
    send(0, 8'h50, 0, 0); send(0, 8'h51, 1, 0); send(0, 8'h52, 0, 0);
    send(1, 8'h60, 1, 0); send(1, 8'h61, 0, 0); send(1, 8'h62, 1, 0);
    expect_beat(8'h50, 0); expect_beat(8'h60, 0); expect_beat(8'h51, 0);
    expect_beat(8'h61, 0); expect_beat(8'h52, 0); expect_beat(8'h62, 0);
    tick(2);
    check("t5_grant0", m_grant, 4'b0001);
    tick(2);
    check("t5_grant1", m_grant, 4'b0010);
    tick(2);
    check("t5_grant0b", m_grant, 4'b0001);
    wait_drain(100);

    // Reset in the middle of a stream 2 packet; pointer first moved away from 0.
    do_reset(0);
    send(1, 8'h70, 1, 0);
    expect_beat(8'h70, 1);
    wait_drain(50);
    send(2, 8'h71, 0, 0); send(2, 8'h72, 0, 0); send(2, 8'h73, 0, 0); send(2, 8'h74, 1, 0);
    expect_beat(8'h71, 0); expect_beat(8'h72, 0);
    repeat (4) @(posedge clock);
    #2;
    resetn = 1'b0;
    for (int i = 0; i < N; i++) srcq[i].delete();
    ivalid = '0;
    send(0, 8'h80, 1, 0);
    send(2, 8'h81, 1, 0);
    expect_beat(8'h80, 1); expect_beat(8'h81, 1);
    tick(2);
    check("t6_ovalid", m_ovalid, 0);
    check("t6_grant", m_grant, 0);
    check("t6_olast", m_olast, 0);
    resetn = 1'b1;
    tick(1);
    check("t6_grant_after", m_grant, 4'b0001);
    wait_drain(100);

    check("leftover_expected", expq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
